// File: rtl/tcm_pkg.sv
// tcm_pkg: shared constants and types for the two-counter machine core.
//   INSTR_W          instruction width
//   OP_*             3-bit opcodes held in instr[7:5]
//   FETCH_BUF_DEPTH  fetch buffer depth; 2 when FETCH_PREFETCH_EN is defined, else 1
//   fetch_state_e    fetch stage state
package tcm_pkg;
   localparam int INSTR_W = 8;
   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_CLR  = 3'b001;
   localparam logic [2:0] OP_INC  = 3'b010;
   localparam logic [2:0] OP_DEC  = 3'b011;
   localparam logic [2:0] OP_CPY  = 3'b100;
   localparam logic [2:0] OP_JMPZ = 3'b101;
   localparam logic [2:0] OP_JMPE = 3'b110;
   localparam logic [2:0] OP_HALT = 3'b111;
`ifdef FETCH_PREFETCH_EN
   localparam logic [1:0] FETCH_BUF_DEPTH = 2'd2;
`else
   localparam logic [1:0] FETCH_BUF_DEPTH = 2'd1;
`endif
   typedef enum logic [1:0] {ST_RUN, ST_STOP, ST_HALTED} fetch_state_e;
endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: shift-register FIFO of {instr, pc}, depth FETCH_BUF_DEPTH (FETCH_PREFETCH_EN).
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_push, i_instr, i_pc   write an entry
//   i_pop                   drop the head entry
//   i_flush                 empty the buffer
//   o_instr, o_pc           head entry, straight from registers
//   o_count, o_full, o_empty occupancy
module fetch_buf
   import tcm_pkg::*;
#(
   parameter int PC_W = 8
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_push,
   input  logic               i_pop,
   input  logic               i_flush,
   input  logic [INSTR_W-1:0] i_instr,
   input  logic [PC_W-1:0]    i_pc,
   output logic [INSTR_W-1:0] o_instr,
   output logic [PC_W-1:0]    o_pc,
   output logic [1:0]         o_count,
   output logic               o_full,
   output logic               o_empty
);
   localparam int E = INSTR_W + PC_W;
   localparam int D = int'(FETCH_BUF_DEPTH);
   logic [D*E-1:0] r_data, w_data_n;
   logic [1:0]     r_count, w_wr_idx;
   // Entry 0 is the head; a pop shifts everything down one slot before the push lands.
   assign w_wr_idx = r_count - 2'(i_pop);
   always_comb begin
      w_data_n = i_pop ? r_data >> E : r_data;
      for (int i = 0; i < D; i++)
         if (i_push && w_wr_idx == 2'(i)) w_data_n[i*E +: E] = {i_instr, i_pc};
   end
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_data  <= '0;
         r_count <= '0;
      end else begin
         r_data  <= w_data_n;
         r_count <= i_flush ? 2'd0 : r_count + 2'(i_push) - 2'(i_pop);
      end
   end
   assign {o_instr, o_pc} = r_data[E-1:0];
   assign o_count = r_count;
   assign o_full  = r_count == FETCH_BUF_DEPTH;
   assign o_empty = r_count == 2'd0;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage (PC, imem req/ack, fetch buffer, redirect, halt).
//   Buffer depth follows FETCH_PREFETCH_EN (2 entries when defined, 1 otherwise).
//   i_clk, i_rst_n                     clock, synchronous active-low reset
//   o_imem_req, o_imem_addr            read request, held until i_imem_ack
//   i_imem_ack, i_imem_rdata           read completion and data
//   o_instr, o_instr_pc, o_instr_valid instruction to decode
//   i_instr_ready                      consumer accept
//   i_jmp_take, i_jmp_pc, i_jmp_imm    redirect to jmp_pc + jmp_imm
//   o_halted                           HALT consumed, fetch stopped until reset
module fetch_unit
   import tcm_pkg::*;
#(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   output logic               o_imem_req,
   output logic [PC_W-1:0]    o_imem_addr,
   input  logic               i_imem_ack,
   input  logic [INSTR_W-1:0] i_imem_rdata,
   output logic [INSTR_W-1:0] o_instr,
   output logic [PC_W-1:0]    o_instr_pc,
   output logic               o_instr_valid,
   input  logic               i_instr_ready,
   input  logic               i_jmp_take,
   input  logic [PC_W-1:0]    i_jmp_pc,
   input  logic [7:0]         i_jmp_imm,
   output logic               o_halted
);
   fetch_state_e r_state, w_state_n;
   logic [PC_W-1:0] r_pc, r_addr, w_pc_n;
   logic r_req, r_squash, r_halted;
   logic w_jmp, w_ack, w_push, w_pop, w_hold, w_full, w_empty;
   logic [1:0] w_count, w_count_n;
   assign w_jmp  = i_jmp_take && r_state != ST_HALTED;
   assign w_ack  = r_req && i_imem_ack;
   // Data returning for a squashed read, or racing a redirect, is dropped.
   assign w_push = w_ack && !r_squash && !w_jmp && !w_full;
   assign o_instr_valid = !w_empty && r_state != ST_HALTED;
   assign w_pop  = o_instr_valid && i_instr_ready;
   assign w_hold = r_req && !i_imem_ack;
   assign w_count_n = w_jmp ? 2'd0 : w_count + 2'(w_push) - 2'(w_pop);
   always_comb begin
      w_state_n = w_jmp ? ST_RUN :
                  (w_pop && o_instr[INSTR_W-1 -: 3] == OP_HALT) ? ST_HALTED :
                  (w_push && i_imem_rdata[INSTR_W-1 -: 3] == OP_HALT) ? ST_STOP : r_state;
      w_pc_n = w_jmp ? PC_W'(8'(i_jmp_pc) + i_jmp_imm) : w_push ? r_pc + PC_W'(1) : r_pc;
   end
   fetch_buf #(.PC_W(PC_W)) u_buf (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (w_jmp),
      .i_instr (i_imem_rdata),
      .i_pc    (r_pc),
      .o_instr (o_instr),
      .o_pc    (o_instr_pc),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );
   // An unacknowledged request keeps its address; otherwise the next request
   // targets the updated PC once the buffer will have room after this cycle.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state  <= ST_RUN;
         r_pc     <= RESET_PC;
         r_addr   <= RESET_PC;
         r_req    <= 1'b0;
         r_squash <= 1'b0;
         r_halted <= 1'b0;
      end else begin
         r_state  <= w_state_n;
         r_pc     <= w_pc_n;
         r_addr   <= w_hold ? r_addr : w_pc_n;
         r_req    <= w_hold || (w_state_n == ST_RUN && w_count_n < FETCH_BUF_DEPTH);
         r_squash <= (w_jmp && w_hold) ? 1'b1 : w_ack ? 1'b0 : r_squash;
         r_halted <= w_state_n == ST_HALTED;
      end
   end
   assign o_imem_req  = r_req;
   assign o_imem_addr = r_addr;
   assign o_halted    = r_halted;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit (directed tables plus randomized scoreboard).
module tb_fetch_unit;
`ifdef FETCH_PREFETCH_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif
   logic clk = 1'b0, rst_n = 1'b0;
   logic imem_req, imem_ack = 1'b0, instr_valid, instr_ready = 1'b0;
   logic jmp_take = 1'b0, halted;
   logic [7:0] imem_addr, imem_rdata, instr, instr_pc;
   logic [7:0] jmp_pc = 8'h00, jmp_imm = 8'h00;
   logic [7:0] mem [256];
   assign imem_rdata = mem[imem_addr];

   fetch_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .o_imem_req(imem_req), .o_imem_addr(imem_addr),
      .i_imem_ack(imem_ack), .i_imem_rdata(imem_rdata),
      .o_instr(instr), .o_instr_pc(instr_pc), .o_instr_valid(instr_valid),
      .i_instr_ready(instr_ready),
      .i_jmp_take(jmp_take), .i_jmp_pc(jmp_pc), .i_jmp_imm(jmp_imm),
      .o_halted(halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] jpc;
      logic [7:0] jimm;
      logic [7:0] tgt;
   } jvec_t;
   jvec_t jv [5];

   int n_chk = 0, n_fail = 0;
   int acc_n, halt_acc, halt_seen, late_req, late_valid, n_ack, got, exp_pc, n_acc;
   int acc_pc [3];
   logic [7:0] s_instr, s_addr, prev_addr;
   logic prev_hold, jt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      jmp_take = 1'b0;
      imem_ack = 1'b0;
      instr_ready = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic fill_mem();
      for (int i = 0; i < 256; i++) begin
         mem[i] = 8'($urandom);
         if (mem[i][7:5] == 3'b111) mem[i][7] = 1'b0;
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_req"},      32'(imem_req),    32'd0);
      chk({tag, "_addr"},     32'(imem_addr),   32'd0);
      chk({tag, "_valid"},    32'(instr_valid), 32'd0);
      chk({tag, "_instr"},    32'(instr),       32'd0);
      chk({tag, "_instr_pc"}, 32'(instr_pc),    32'd0);
      chk({tag, "_halted"},   32'(halted),      32'd0);
   endtask

   initial begin
      jv[0] = '{8'h05, 8'hFD, 8'h02};
      jv[1] = '{8'hFF, 8'h01, 8'h00};
      jv[2] = '{8'h10, 8'h80, 8'h90};
      jv[3] = '{8'h80, 8'h7F, 8'hFF};
      jv[4] = '{8'hFE, 8'h05, 8'h03};
      fill_mem();
      step();
      step();
      chk_reset("por");

      // HALT program: 0x41, 0x41, 0xE0
      mem[0] = 8'h41; mem[1] = 8'h41; mem[2] = 8'hE0;
      reset_dut();
      imem_ack = 1'b1;
      instr_ready = 1'b1;
      acc_n = 0; halt_acc = -1; halt_seen = -1; late_req = 0; late_valid = 0;
      for (int i = 0; i < 3; i++) acc_pc[i] = -1;
      for (int c = 0; c < 16; c++) begin
         step();
         if (c == 0) begin
            chk("first_req", 32'(imem_req), 32'd1);
            chk("first_addr", 32'(imem_addr), 32'd0);
         end
         if (halted && halt_seen < 0) halt_seen = c;
         if (halt_seen >= 0) begin
            late_req += 32'(imem_req);
            late_valid += 32'(instr_valid);
         end
         if (instr_valid && instr_ready) begin
            if (acc_n < 3) acc_pc[acc_n] = 32'(instr_pc);
            acc_n++;
            if (instr[7:5] == 3'b111) halt_acc = c;
         end
      end
      chk("halt_prog_count", acc_n, 3);
      chk("halt_prog_pc0", acc_pc[0], 0);
      chk("halt_prog_pc1", acc_pc[1], 1);
      chk("halt_prog_pc2", acc_pc[2], 2);
      chk("halted_delay", halt_seen, halt_acc + 1);
      chk("req_after_halt", late_req, 0);
      chk("valid_after_halt", late_valid, 0);
      jmp_take = 1'b1; jmp_pc = 8'h05; jmp_imm = 8'h00;
      step();
      jmp_take = 1'b0;
      chk("halted_jmp_ignored", 32'(halted), 32'd1);
      chk("halted_jmp_req", 32'(imem_req), 32'd0);

      // redirect table
      fill_mem();
      foreach (jv[k]) begin
         reset_dut();
         imem_ack = 1'b1;
         repeat (3) step();
         jmp_take = 1'b1; jmp_pc = jv[k].jpc; jmp_imm = jv[k].jimm;
         step();
         jmp_take = 1'b0;
         chk($sformatf("jmp%0d_valid", k), 32'(instr_valid), 32'd0);
         chk($sformatf("jmp%0d_req", k), 32'(imem_req), 32'd1);
         chk($sformatf("jmp%0d_addr", k), 32'(imem_addr), 32'(jv[k].tgt));
         instr_ready = 1'b1;
         got = -1;
         for (int c = 0; c < 10 && got < 0; c++) begin
            if (instr_valid) got = 32'(instr_pc);
            else step();
         end
         chk($sformatf("jmp%0d_first_pc", k), got, 32'(jv[k].tgt));
      end

      // squash: ack delayed 3 cycles, redirect in the request's second cycle
      reset_dut();
      instr_ready = 1'b1;
      step();
      chk("sq_req0", 32'(imem_req), 32'd1);
      step();
      jmp_take = 1'b1; jmp_pc = 8'h20; jmp_imm = 8'h10;
      step();
      jmp_take = 1'b0;
      chk("sq_hold_req", 32'(imem_req), 32'd1);
      chk("sq_hold_addr", 32'(imem_addr), 32'h00);
      step();
      imem_ack = 1'b1;
      chk("sq_ack_addr", 32'(imem_addr), 32'h00);
      step();
      chk("sq_drop_valid", 32'(instr_valid), 32'd0);
      chk("sq_next_addr", 32'(imem_addr), 32'h30);
      got = -1;
      for (int c = 0; c < 10 && got < 0; c++) begin
         if (instr_valid) begin
            got = 32'(instr_pc);
            chk("sq_first_instr", 32'(instr), 32'(mem[8'h30]));
         end else step();
      end
      chk("sq_first_pc", got, 32'h30);

      // consumer stalled: buffer fills, then everything holds
      reset_dut();
      imem_ack = 1'b1;
      n_ack = 0;
      for (int c = 0; c < 8; c++) begin
         step();
         if (imem_req && imem_ack) n_ack++;
         if (c == 0) chk("lat_valid0", 32'(instr_valid), 32'd0);
         if (c == 1) chk("lat_valid1", 32'(instr_valid), 32'd1);
         if (c == 2) begin
            s_instr = instr;
            s_addr = imem_addr;
         end
      end
      chk("stall_fetches", n_ack, DEPTH);
      chk("stall_instr", 32'(instr), 32'(s_instr));
      chk("stall_instr_mem", 32'(instr), 32'(mem[0]));
      chk("stall_instr_pc", 32'(instr_pc), 32'd0);
      chk("stall_addr", 32'(imem_addr), 32'(s_addr));
      chk("stall_addr_val", 32'(imem_addr), DEPTH);

      // PC wrap at 0xFF
      reset_dut();
      jmp_take = 1'b1; jmp_pc = 8'hFF; jmp_imm = 8'h00;
      imem_ack = 1'b1;
      instr_ready = 1'b1;
      step();
      jmp_take = 1'b0;
      chk("wrap_addr_ff", 32'(imem_addr), 32'hFF);
      step();
      chk("wrap_addr_00", 32'(imem_addr), 32'h00);
      acc_n = 0;
      acc_pc[0] = -1; acc_pc[1] = -1;
      for (int c = 0; c < 10 && acc_n < 2; c++) begin
         if (instr_valid) begin
            acc_pc[acc_n] = 32'(instr_pc);
            acc_n++;
         end
         step();
      end
      chk("wrap_pc0", acc_pc[0], 32'hFF);
      chk("wrap_pc1", acc_pc[1], 32'h00);

      // reset during a pending request
      reset_dut();
      imem_ack = 1'b1;
      step();
      imem_ack = 1'b0;
      step();
      rst_n = 1'b0;
      step();
      chk_reset("midrst");
      rst_n = 1'b1;
      step();
      chk("midrst_req_again", 32'(imem_req), 32'd1);
      chk("midrst_addr_again", 32'(imem_addr), 32'd0);

      // randomized: consumer sees consecutive PCs from the latest redirect target
      fill_mem();
      reset_dut();
      exp_pc = 0; n_acc = 0; prev_hold = 1'b0; prev_addr = 8'h00;
      for (int c = 0; c < 3000; c++) begin
         step();
         if (prev_hold) begin
            chk("rnd_hold_req", 32'(imem_req), 32'd1);
            chk("rnd_hold_addr", 32'(imem_addr), 32'(prev_addr));
         end
         imem_ack = 1'($urandom_range(0, 1));
         instr_ready = $urandom_range(0, 3) != 0;
         jt = $urandom_range(0, 15) == 0;
         jmp_take = jt;
         jmp_pc = 8'($urandom);
         jmp_imm = 8'($urandom);
         if (instr_valid && instr_ready) begin
            chk("rnd_pc", 32'(instr_pc), exp_pc);
            chk("rnd_instr", 32'(instr), 32'(mem[exp_pc]));
            exp_pc = (exp_pc + 1) % 256;
            n_acc++;
         end
         if (jt) exp_pc = (int'(jmp_pc) + int'(jmp_imm)) % 256;
         prev_hold = imem_req && !imem_ack;
         prev_addr = imem_addr;
      end
      jmp_take = 1'b0;
      chk("rnd_progress", 32'(n_acc > 300), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
